// File: rtl/fsc_sync_deframer.sv
// ============================================================================
// Module   : fsc_sync_deframer
// Purpose  : Serial frame-sync deframer. It hunts for, verifies and flywheels a sync word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsc_sync_deframer #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FRAME_BYTES = 4,
    parameter int         MISS_LIMIT  = 2
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       id,
    input  logic       ien,
    output logic [7:0] odata,
    output logic       ovalid,
    output logic       osof,
    output logic       olock,
    output logic [7:0] oerr_cnt
);

    localparam int            BW           = $clog2(FRAME_BYTES + 1);
    localparam logic [BW-1:0] C_LAST_BYTE  = BW'(FRAME_BYTES - 1);
    localparam logic [3:0]    C_MISS_LIMIT = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_VERIFY  = 2'd2
    } state_t;

    state_t        r_state,    w_state_nx;
    logic [7:0]    r_shift,    w_shift_nx;
    logic [3:0]    r_fill,     w_fill_nx;
    logic [2:0]    r_bit_cnt,  w_bit_cnt_nx;
    logic [BW-1:0] r_byte_cnt, w_byte_cnt_nx;
    logic [3:0]    r_miss,     w_miss_nx;
    logic [7:0]    r_data,     w_data_nx;
    logic [7:0]    r_err,      w_err_nx;
    logic          r_valid,    w_valid_nx;
    logic          r_sof,      w_sof_nx;
    logic [7:0]    w_shift_in;

    assign w_shift_in = {r_shift[6:0], id};

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state    <= ST_HUNT;
            r_shift    <= 8'd0;
            r_fill     <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_miss     <= 4'd0;
            r_data     <= 8'd0;
            r_err      <= 8'd0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_fill     <= w_fill_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_miss     <= w_miss_nx;
            r_data     <= w_data_nx;
            r_err      <= w_err_nx;
            r_valid    <= w_valid_nx;
            r_sof      <= w_sof_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_fill_nx     = r_fill;
        w_bit_cnt_nx  = r_bit_cnt;
        w_byte_cnt_nx = r_byte_cnt;
        w_miss_nx     = r_miss;
        w_data_nx     = r_data;
        w_err_nx      = r_err;
        w_valid_nx    = 1'b0;
        w_sof_nx      = 1'b0;
        if (ien) begin
            w_shift_nx = w_shift_in;
            case (r_state)
                ST_HUNT: begin
                    if (r_fill != 4'd8)
                        w_fill_nx = r_fill + 4'd1;
                    // r_fill >= 7 means this bit is at least the 8th since entry
                    if ((r_fill >= 4'd7) && (w_shift_in == SYNC_WORD)) begin
                        w_state_nx    = ST_PAYLOAD;
                        w_bit_cnt_nx  = 3'd0;
                        w_byte_cnt_nx = '0;
                        w_miss_nx     = 4'd0;
                    end
                end
                ST_PAYLOAD: begin
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_data_nx  = w_shift_in;
                        w_valid_nx = 1'b1;
                        w_sof_nx   = (r_byte_cnt == '0);
                        if (r_byte_cnt == C_LAST_BYTE) begin
                            w_state_nx    = ST_VERIFY;
                            w_bit_cnt_nx  = 3'd0;
                            w_byte_cnt_nx = '0;
                        end else begin
                            w_byte_cnt_nx = r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_nx = 3'd0;
                        if (w_shift_in == SYNC_WORD) begin
                            w_state_nx = ST_PAYLOAD;
                            w_miss_nx  = 4'd0;
                        end else begin
                            if (r_err != 8'hFF)
                                w_err_nx = r_err + 8'd1;
                            w_miss_nx = r_miss + 4'd1;
                            if ((r_miss + 4'd1) == C_MISS_LIMIT) begin
                                w_state_nx = ST_HUNT;
                                w_shift_nx = 8'd0;
                                w_fill_nx  = 4'd0;
                            end else begin
                                w_state_nx = ST_PAYLOAD;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                    w_shift_nx = 8'd0;
                    w_fill_nx  = 4'd0;
                end
            endcase
        end
    end

    assign odata    = r_data;
    assign ovalid   = r_valid;
    assign osof     = r_sof;
    assign olock    = (r_state != ST_HUNT);
    assign oerr_cnt = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fsc_sync_deframer.sv
// ============================================================================
// Module   : tb_fsc_sync_deframer
// Purpose  : Directed self-checking bench for fsc_sync_deframer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsc_sync_deframer;

    logic       clk;
    logic       rst_n;
    logic       id;
    logic       ien;
    logic [7:0] odata;
    logic       ovalid;
    logic       osof;
    logic       olock;
    logic [7:0] oerr_cnt;
    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_sof;
    logic       d2_lock;
    logic [7:0] d2_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q[$];
    logic       prev_en = 1'b0;
    int         en_viol = 0;

    fsc_sync_deframer #(.SYNC_WORD(8'hA5), .FRAME_BYTES(2), .MISS_LIMIT(2)) dut (
        .iclk(clk), .irst_n(rst_n), .id(id), .ien(ien),
        .odata(odata), .ovalid(ovalid), .osof(osof), .olock(olock), .oerr_cnt(oerr_cnt)
    );

    fsc_sync_deframer #(.SYNC_WORD(8'hA5), .FRAME_BYTES(2), .MISS_LIMIT(15)) dut2 (
        .iclk(clk), .irst_n(rst_n), .id(id), .ien(ien),
        .odata(d2_data), .ovalid(d2_valid), .osof(d2_sof), .olock(d2_lock), .oerr_cnt(d2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output byte log ({osof, odata}) and a count of pulses after ien=0 edges
    always @(posedge clk) prev_en <= ien;
    always @(negedge clk) begin
        if (rst_n && ovalid) begin
            q.push_back({osof, odata});
            if (!prev_en) en_viol <= en_viol + 1;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        id  = b;
        ien = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_gap();
        @(negedge clk);
        id  = 1'($urandom_range(0, 1));
        ien = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic toggle);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (toggle) send_gap();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ien   = 1'b0;
        id    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        en_viol = 0;
    endtask

    task automatic test_reset();
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h33, 1'b0);
        n_cmp++;
        if ({ovalid, osof, odata, olock, oerr_cnt} !== {1'b1, 1'b1, 8'h33, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL pre_reset: got v=%b s=%b d=%h l=%b e=%0d, want v=1 s=1 d=33 l=1 e=1",
                     ovalid, osof, odata, olock, oerr_cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ovalid, osof, odata, olock, oerr_cnt} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b s=%b d=%h l=%b e=%0d, want all 0",
                     ovalid, osof, odata, olock, oerr_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream(input logic toggle);
        logic [8:0] exp [4];
        logic [7:0] sw;
        exp = '{9'h112, 9'h034, 9'h156, 9'h078};
        sw  = 8'hA5;
        do_reset();
        send_byte(8'h00, toggle);
        for (int i = 7; i >= 1; i--) begin
            send_bit(sw[i]);
            if (toggle) send_gap();
        end
        n_cmp++;
        if (olock !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_bit15 tg=%b: got %b want 0", toggle, olock);
        end
        send_bit(sw[0]);
        n_cmp++;
        if (olock !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_bit16 tg=%b: got %b want 1", toggle, olock);
        end
        if (toggle) send_gap();
        send_byte(8'h12, toggle);
        send_byte(8'h34, toggle);
        send_byte(8'hA5, toggle);
        send_byte(8'h56, toggle);
        send_byte(8'h78, toggle);
        send_gap();
        n_cmp++;
        if (q.size() != 4) begin
            n_bad++;
            $display("FAIL stream_count tg=%b: got %0d want 4", toggle, q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL stream_byte%0d tg=%b: got %h want %h", i, toggle, q[i], exp[i]);
            end
        end
        n_cmp++;
        if (oerr_cnt !== 8'd0 || en_viol != 0) begin
            n_bad++;
            $display("FAIL stream_err_en tg=%b: got err=%0d viol=%0d want 0/0", toggle, oerr_cnt, en_viol);
        end
    endtask

    task automatic test_flywheel();
        logic [8:0] exp [4];
        exp = '{9'h111, 9'h022, 9'h19A, 9'h0BC};
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'hA4, 1'b0);
        n_cmp++;
        if (olock !== 1'b1 || oerr_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL flywheel_state: got lock=%b err=%0d want 1/1", olock, oerr_cnt);
        end
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_gap();
        n_cmp++;
        if (q.size() != 4) begin
            n_bad++;
            $display("FAIL flywheel_count: got %0d want 4", q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL flywheel_byte%0d: got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_loss();
        logic [8:0] exp [5];
        logic [7:0] ff;
        exp = '{9'h111, 9'h022, 9'h133, 9'h044, 9'h15A};
        ff  = 8'hFF;
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(ff[i]);
        n_cmp++;
        if (olock !== 1'b1 || oerr_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL loss_before: got lock=%b err=%0d want 1/1", olock, oerr_cnt);
        end
        send_bit(ff[0]);
        n_cmp++;
        if (olock !== 1'b0 || oerr_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL loss_edge: got lock=%b err=%0d want 0/2", olock, oerr_cnt);
        end
        send_byte(8'h12, 1'b0);
        n_cmp++;
        if (olock !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_fill: got lock=%b want 0", olock);
        end
        send_byte(8'hA5, 1'b0);
        n_cmp++;
        if (olock !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_relock: got lock=%b want 1", olock);
        end
        send_byte(8'h5A, 1'b0);
        send_gap();
        n_cmp++;
        if (q.size() != 5) begin
            n_bad++;
            $display("FAIL loss_count: got %0d want 5", q.size());
        end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL loss_byte%0d: got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_sync_in_payload();
        logic [8:0] exp [4];
        exp = '{9'h1A5, 9'h0A5, 9'h101, 9'h002};
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_gap();
        n_cmp++;
        if (q.size() != 4 || olock !== 1'b1 || oerr_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL syncdata_state: got n=%0d lock=%b err=%0d want 4/1/0", q.size(), olock, oerr_cnt);
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL syncdata_byte%0d: got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_byte(8'hA5, 1'b0);
        for (int r = 0; r < 20; r++) begin
            for (int m = 0; m < 15; m++) begin
                send_byte(8'h11, 1'b0);
                send_byte(8'h22, 1'b0);
                send_byte(8'h00, 1'b0);
                if (r == 0 && m == 13) begin
                    n_cmp++;
                    if (d2_lock !== 1'b1 || d2_err !== 8'd14) begin
                        n_bad++;
                        $display("FAIL sat_miss14: got lock=%b err=%0d want 1/14", d2_lock, d2_err);
                    end
                end
            end
            if (r == 0) begin
                n_cmp++;
                if (d2_lock !== 1'b0 || d2_err !== 8'd15) begin
                    n_bad++;
                    $display("FAIL sat_miss15: got lock=%b err=%0d want 0/15", d2_lock, d2_err);
                end
            end
            send_byte(8'hA5, 1'b0);
        end
        n_cmp++;
        if (d2_err !== 8'hFF || d2_lock !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_final: got err=%h lock=%b want FF/1", d2_err, d2_lock);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id    = 1'b0;
        ien   = 1'b0;
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_flywheel();
        test_loss();
        test_sync_in_payload();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsc_sync_deframer.md
FSC_SYNC_DEFRAMER -- requirements
Module: fsc_sync_deframer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5, the 8-bit frame sync pattern, received MSB first.
REQ-002 Parameter FRAME_BYTES, default 4, the number of payload bytes between sync words; legal range 1..255.
REQ-003 Parameter MISS_LIMIT, default 2, the number of consecutive bad sync words that causes loss of lock; legal range 1..15.
REQ-004 Port iclk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 Port irst_n, input, 1, asynchronous active-low reset.
REQ-006 Port id, input, 1, serial data bit, MSB first, sampled only when ien=1.
REQ-007 Port ien, input, 1, bit-valid qualifier; when low, no state, counter or shift register changes.
REQ-008 Port odata, output, 8, the last completed payload byte.
REQ-009 Port ovalid, output, 1, one-cycle pulse marking a new odata.
REQ-010 Port osof, output, 1, one-cycle pulse, coincident with ovalid, on the first payload byte of each frame.
REQ-011 Port olock, output, 1, frame lock indicator.
REQ-012 Port oerr_cnt, output, 8, count of bad sync words, saturating.

Function
REQ-013 The block shall implement a 3-state FSM with states HUNT, PAYLOAD and VERIFY.
REQ-014 olock shall be 1 in PAYLOAD and VERIFY, and 0 in HUNT.
REQ-015 HUNT: each enabled bit shifts into an 8-bit register (new bit at the LSB), and the register is compared with SYNC_WORD.
REQ-016 On entry to HUNT, the shift register and a fill counter shall clear; a match is honoured only after 8 enabled bits since entry.
REQ-017 HUNT match: go to PAYLOAD with bit counter 0, byte counter 0 and miss counter 0; olock rises at the same edge.
REQ-018 PAYLOAD: 8 enabled bits form one byte; at the edge sampling bit 8, odata is loaded and ovalid=1 for exactly that following cycle.
REQ-019 osof shall be 1 with ovalid when the byte counter was 0.
REQ-020 After FRAME_BYTES bytes, PAYLOAD shall go to VERIFY with the bit counter cleared.
REQ-021 VERIFY: 8 enabled bits are collected and compared with SYNC_WORD; no ovalid is issued for these bits.
REQ-022 VERIFY match: go to PAYLOAD and clear the miss counter.
REQ-023 VERIFY mismatch: increment oerr_cnt (saturating at 255) and increment the miss counter.
REQ-024 After a mismatch, if the miss counter equals MISS_LIMIT, go to HUNT (olock falls at that edge); otherwise go to PAYLOAD (flywheel), treating the bad byte as a sync.
REQ-025 Sync-pattern bytes inside the payload while locked shall be ignored and output as data.
REQ-026 ovalid and osof shall be 0 whenever the edge did not complete a payload byte, including all cycles with ien=0.
REQ-027 odata shall hold its value between ovalid pulses.
REQ-028 The byte counter shall be at least clog2(FRAME_BYTES+1) bits wide, the bit counter 3 bits wide, and the miss counter 4 bits wide.

Reset
REQ-029 While irst_n=0, the block shall asynchronously force: FSM=HUNT, all counters and the shift register 0, odata=0, ovalid=0, osof=0, olock=0, oerr_cnt=0.
REQ-030 Reset deassertion takes effect at the next iclk edge.
REQ-031 Reset mid-frame discards the partial byte; recovery requires a fresh HUNT match after 8 new bits.

Verification (SYNC_WORD=A5, FRAME_BYTES=2, MISS_LIMIT=2, ien=1 unless stated)
REQ-032 Scenario: assert irst_n=0 asynchronously mid-clock -> all outputs 0 immediately, oerr_cnt=0.
REQ-033 Scenario: stream 00,A5,12,34,A5,56,78 -> olock rises after the 16th bit; ovalid pulses with odata 12(osof=1), 34, 56(osof=1), 78; oerr_cnt=0.
REQ-034 Scenario: lock, then stream A4 as sync, then 9A,BC -> oerr_cnt=1, olock stays 1, and 9A(osof)/BC are output.
REQ-035 Scenario: lock, then two consecutive bad syncs (00,FF) -> oerr_cnt=2, olock=0 at the edge sampling the last bit of FF, and no ovalid until a new A5 plus 8 fill bits.
REQ-036 Scenario: repeat the stream of REQ-033 with ien toggling 1,0 each cycle -> identical odata sequence, and no ovalid in any ien=0 cycle.
REQ-037 Scenario: lock, send payload A5,A5, then a valid A5 sync -> both A5 bytes are output as data and olock stays 1; drive 300 bad syncs with MISS_LIMIT=15 -> oerr_cnt saturates at FF.
